// File: rtl/fifo_pkg.sv
// Shared definitions for the clk_a-side FIFO writers: default widths and
// the packer's state/phase encodings.
package fifo_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_WIDTH = 2 * BYTE_W;

    // Packer control state: accumulating data bytes, or owing a trailer word.
    typedef enum logic {
        ACC = 1'b0,
        TRL = 1'b1
    } state_t;

    // Which half of the next output word the incoming byte fills.
    typedef enum logic {
        HI = 1'b0,
        LO = 1'b1
    } phase_t;

endpackage

// File: rtl/fifo_byte_packer_if.sv
// Bundle of the byte-stream input, FIFO write port and packet status of the
// byte packer. master = stream source / FIFO side, slave = the packer.
interface fifo_byte_packer_if #(
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) ();

    logic [BYTE_W-1:0]   in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic                fifo_full;
    logic [2*BYTE_W-1:0] din_a;
    logic                wen_a;
    logic                pkt_done;
    logic [CNT_W-1:0]    pkt_count;

    modport master (
        output in_data, in_valid, in_last, fifo_full,
        input  in_ready, din_a, wen_a, pkt_done, pkt_count
    );

    modport slave (
        input  in_data, in_valid, in_last, fifo_full,
        output in_ready, din_a, wen_a, pkt_done, pkt_count
    );

endinterface

// File: rtl/fifo_out_slot.sv
// Single-entry output holding register in front of the dual-clock FIFO write
// port. A loaded word is held on din_a until the FIFO accepts it; a load may
// coincide with the drain of the previous word, so one word per cycle can be
// sustained while the FIFO is not full.
module fifo_out_slot #(
    parameter int W = 16
) (
    input  logic         clk_a,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         fifo_full,
    output logic [W-1:0] din_a,
    output logic         wen_a,
    output logic         slot_free
);

    logic pend;

    // Write strobe is suppressed during reset so a discarded word never leaks out.
    assign wen_a     = pend && !fifo_full && !rst;
    assign slot_free = !pend || wen_a;

    // Hold register: load wins over drain so pend stays set with the new word.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            pend  <= 1'b0;
            din_a <= {W{1'b0}};
        end else if (load) begin
            din_a <= load_data;
            pend  <= 1'b1;
        end else if (wen_a) begin
            pend  <= 1'b0;
        end else begin
            pend  <= pend;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Write-side feeder for the dual-clock 16-bit FIFO. Packs a framed byte
// stream into words (first byte in the high half), pads an odd final byte,
// optionally appends a byte-count trailer word per packet and writes the
// result through a single-entry output slot that respects fifo_full.
module fifo_byte_packer #(
    parameter int              BYTE_W     = 8,
    parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00,
    parameter bit              TRAILER_EN = 1'b1,
    parameter int              CNT_W      = 16
) (
    input  logic             clk_a,
    input  logic             rst,
    fifo_byte_packer_if.slave bus
);

    import fifo_pkg::*;

    localparam int WORD_W = 2 * BYTE_W;

    state_t              state;
    phase_t              phase;
    logic [BYTE_W-1:0]   hi_reg;
    logic [CNT_W-1:0]    byte_cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    pkt_count;
    logic                pkt_done;

    logic                in_ready;
    logic                accept;
    logic                slot_free;
    logic                load;
    logic [WORD_W-1:0]   load_data;
    logic                finish;

    // Saturating byte counter increment: stays at all-ones on overflow.
    always_comb begin
        if (&byte_cnt) begin
            cnt_inc = byte_cnt;
        end else begin
            cnt_inc = byte_cnt + CNT_W'(1'b1);
        end
    end

    // Ready: a high byte that does not end the packet only needs hi_reg; any
    // byte that completes a word needs the output slot to be free.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (state == ACC) begin
            in_ready = slot_free || ((phase == HI) && !bus.in_last);
        end else begin
            in_ready = 1'b0;
        end
    end

    assign accept = bus.in_valid && in_ready;

    // Word assembly: decide what (if anything) is loaded into the slot this
    // cycle and whether that load completes the packet.
    always_comb begin
        load      = 1'b0;
        load_data = {WORD_W{1'b0}};
        finish    = 1'b0;
        case (state)
            ACC: begin
                if (accept && (phase == LO)) begin
                    load      = 1'b1;
                    load_data = {hi_reg, bus.in_data};
                    finish    = bus.in_last && !TRAILER_EN;
                end else if (accept && bus.in_last) begin
                    load      = 1'b1;
                    load_data = {bus.in_data, PAD_BYTE};
                    finish    = !TRAILER_EN;
                end else begin
                    load      = 1'b0;
                end
            end
            TRL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = WORD_W'(byte_cnt);
                    finish    = 1'b1;
                end else begin
                    load      = 1'b0;
                end
            end
            default: begin
                load   = 1'b0;
                finish = 1'b0;
            end
        endcase
    end

    // Packing FSM: phase/state sequencing, byte count and packet statistics.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state     <= ACC;
            phase     <= HI;
            hi_reg    <= {BYTE_W{1'b0}};
            byte_cnt  <= {CNT_W{1'b0}};
            pkt_count <= {CNT_W{1'b0}};
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= finish;
            if (finish) begin
                byte_cnt  <= {CNT_W{1'b0}};
                pkt_count <= pkt_count + CNT_W'(1'b1);
                state     <= ACC;
                phase     <= HI;
            end else begin
                case (state)
                    ACC: begin
                        if (accept) begin
                            byte_cnt <= cnt_inc;
                            if (phase == HI) begin
                                hi_reg <= bus.in_data;
                                if (bus.in_last) begin
                                    state <= TRL;
                                    phase <= HI;
                                end else begin
                                    phase <= LO;
                                end
                            end else begin
                                phase <= HI;
                                if (bus.in_last) begin
                                    state <= TRL;
                                end else begin
                                    state <= ACC;
                                end
                            end
                        end else begin
                            state <= ACC;
                        end
                    end
                    TRL: begin
                        state <= TRL;
                    end
                    default: begin
                        state <= ACC;
                        phase <= HI;
                    end
                endcase
            end
        end
    end

    fifo_out_slot #(
        .W (WORD_W)
    ) u_slot (
        .clk_a     (clk_a),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .fifo_full (bus.fifo_full),
        .din_a     (bus.din_a),
        .wen_a     (bus.wen_a),
        .slot_free (slot_free)
    );

    assign bus.in_ready  = in_ready;
    assign bus.pkt_done  = pkt_done;
    assign bus.pkt_count = pkt_count;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: one instance with trailer words and
// a zero pad byte, one without trailers and a non-zero pad byte.
module tb_fifo_byte_packer;

    localparam logic [7:0] PAD1 = 8'h00;
    localparam logic [7:0] PAD0 = 8'h5C;

    logic clk_a = 1'b0;
    logic rst   = 1'b1;

    always #5 clk_a = ~clk_a;

    fifo_byte_packer_if #(.BYTE_W(8), .CNT_W(16)) b1 ();
    fifo_byte_packer_if #(.BYTE_W(8), .CNT_W(16)) b0 ();

    fifo_byte_packer #(.BYTE_W(8), .PAD_BYTE(PAD1), .TRAILER_EN(1'b1), .CNT_W(16)) dut1 (
        .clk_a (clk_a),
        .rst   (rst),
        .bus   (b1.slave)
    );

    fifo_byte_packer #(.BYTE_W(8), .PAD_BYTE(PAD0), .TRAILER_EN(1'b0), .CNT_W(16)) dut0 (
        .clk_a (clk_a),
        .rst   (rst),
        .bus   (b0.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q1[$];
    logic [15:0] exp_q0[$];
    logic [15:0] done_q1[$];
    logic [15:0] done_q0[$];
    int pulses1 = 0;
    int pulses0 = 0;
    int sent1   = 0;
    int sent0   = 0;
    int accepted = 0;
    logic [7:0] pkt[$];
    bit ff_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s %s", name, why);
    endtask

    // Reference model: word stream and final word of the packet held in pkt.
    task automatic build_expect(input bit which);
        logic [15:0] w;
        int n;
        n = pkt.size();
        w = 16'h0000;
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) w = {pkt[i], pkt[i+1]};
            else           w = {pkt[i], (which ? PAD1 : PAD0)};
            if (which) exp_q1.push_back(w);
            else       exp_q0.push_back(w);
        end
        if (which) begin
            w = (n > 65535) ? 16'hFFFF : 16'(n);
            exp_q1.push_back(w);
            done_q1.push_back(w);
            sent1++;
        end else begin
            done_q0.push_back(w);
            sent0++;
        end
    endtask

    task automatic drive(input bit which, input logic v, input logic [7:0] d, input logic l);
        if (which) begin
            b1.in_valid = v; b1.in_data = d; b1.in_last = l;
        end else begin
            b0.in_valid = v; b0.in_data = d; b0.in_last = l;
        end
    endtask

    // Issue the bytes of pkt with valid/ready; returns at posedge + 1.
    task automatic send(input bit which, input int gap_max, input bit no_last);
        int n;
        int t;
        int g;
        logic rdy;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                g = int'($urandom_range(0, gap_max));
                repeat (g) begin
                    drive(which, 1'b0, 8'h00, 1'b0);
                    @(posedge clk_a); #1;
                end
            end
            drive(which, 1'b1, pkt[i], (i == n - 1) && !no_last);
            t = 0;
            rdy = 1'b0;
            while (!rdy && t < 200) begin
                @(negedge clk_a);
                rdy = which ? b1.in_ready : b0.in_ready;
                @(posedge clk_a); #1;
                t++;
            end
            if (!rdy) fail_now("send_timeout", "in_ready never rose");
            else      accepted++;
        end
        drive(which, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input bit which);
        int t;
        t = 0;
        while (t < 2000 && (which ? (exp_q1.size() + done_q1.size()) : (exp_q0.size() + done_q0.size())) != 0) begin
            @(posedge clk_a); #1;
            t++;
        end
        if ((which ? (exp_q1.size() + done_q1.size()) : (exp_q0.size() + done_q0.size())) != 0)
            fail_now(which ? "drain1" : "drain0", "expected words never written");
        repeat (4) begin
            @(posedge clk_a); #1;
        end
    endtask

    task automatic rand_pkt();
        int n;
        pkt.delete();
        n = int'($urandom_range(1, 9));
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    // Monitor: compare every FIFO write and every pkt_done pulse against the model.
    always @(negedge clk_a) begin
        if (b1.wen_a === 1'b1) begin
            if (exp_q1.size() == 0) fail_now("wr1_extra", $sformatf("din_a=%h required=none", b1.din_a));
            else check("wr1_data", 32'(b1.din_a), 32'(exp_q1.pop_front()));
        end
        if (b1.pkt_done === 1'b1) begin
            pulses1++;
            if (done_q1.size() == 0) fail_now("done1_extra", "unexpected pkt_done");
            else check("done1_word", 32'(b1.din_a), 32'(done_q1.pop_front()));
        end
        if (b0.wen_a === 1'b1) begin
            if (exp_q0.size() == 0) fail_now("wr0_extra", $sformatf("din_a=%h required=none", b0.din_a));
            else check("wr0_data", 32'(b0.din_a), 32'(exp_q0.pop_front()));
        end
        if (b0.pkt_done === 1'b1) begin
            pulses0++;
            if (done_q0.size() == 0) fail_now("done0_extra", "unexpected pkt_done");
            else check("done0_word", 32'(b0.din_a), 32'(done_q0.pop_front()));
        end
    end

    // Random FIFO back-pressure when enabled.
    initial begin
        b1.fifo_full = 1'b0;
        b0.fifo_full = 1'b0;
        forever begin
            @(posedge clk_a); #1;
            if (ff_rand) begin
                b1.fifo_full = ($urandom_range(0, 2) == 0);
                b0.fifo_full = ($urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        held = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk_a);
        @(negedge clk_a);
        check("rst_in_ready", 32'(b1.in_ready), 32'd0);
        check("rst_wen_a", 32'(b1.wen_a), 32'd0);
        @(posedge clk_a); #1;
        rst = 1'b0;
        @(negedge clk_a);
        check("rst_din_a", 32'(b1.din_a), 32'd0);
        check("rst_pkt_count", 32'(b1.pkt_count), 32'd0);
        check("rst_pkt_done", 32'(b1.pkt_done), 32'd0);
        check("idle_in_ready", 32'(b1.in_ready), 32'd1);
        @(posedge clk_a); #1;

        // 4-byte packet
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_expect(1'b1);
        send(1'b1, 0, 1'b0);
        wait_drain(1'b1);
        check("t1_pkt_count", 32'(b1.pkt_count), 32'(sent1));

        // Odd packet with pad
        pkt = '{8'hAA, 8'hBB, 8'hCC};
        build_expect(1'b1);
        send(1'b1, 0, 1'b0);
        wait_drain(1'b1);

        // fifo_full held 10 cycles during a 6-byte packet
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        build_expect(1'b1);
        accepted = 0;
        b1.fifo_full = 1'b1;
        fork
            send(1'b1, 0, 1'b0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_a);
                    check("full_wen_a", 32'(b1.wen_a), 32'd0);
                    if (i == 2) held = b1.din_a;
                    if (i >= 2) check("full_din_a", 32'(b1.din_a), 32'h0102);
                    if (i >= 3) check("full_din_stable", 32'(b1.din_a), 32'(held));
                end
                check("full_in_ready", 32'(b1.in_ready), 32'd0);
                check("full_accepted", 32'(accepted), 32'd3);
                @(posedge clk_a); #1;
                b1.fifo_full = 1'b0;
            end
        join
        wait_drain(1'b1);

        // Back-to-back packets with continuous valid
        pkt = '{8'h5A};
        build_expect(1'b1);
        send(1'b1, 0, 1'b0);
        pkt = '{8'h01, 8'h02};
        build_expect(1'b1);
        send(1'b1, 0, 1'b0);
        wait_drain(1'b1);
        check("b2b_pkt_count", 32'(b1.pkt_count), 32'(sent1));

        // Reset after byte 2 of a 5-byte packet
        pkt = '{8'hD1, 8'hD2};
        send(1'b1, 0, 1'b1);
        rst = 1'b1;
        @(negedge clk_a);
        check("mid_rst_in_ready", 32'(b1.in_ready), 32'd0);
        check("mid_rst_wen_a", 32'(b1.wen_a), 32'd0);
        @(posedge clk_a); #1;
        @(posedge clk_a); #1;
        rst = 1'b0;
        sent1 = 0; pulses1 = 0; sent0 = 0; pulses0 = 0;
        @(negedge clk_a);
        check("post_rst_pkt_count", 32'(b1.pkt_count), 32'd0);
        @(posedge clk_a); #1;
        pkt = '{8'h77, 8'h88};
        build_expect(1'b1);
        send(1'b1, 0, 1'b0);
        wait_drain(1'b1);
        check("post_rst_count1", 32'(b1.pkt_count), 32'd1);

        // Random packets with random back-pressure
        ff_rand = 1'b1;
        for (int k = 0; k < 25; k++) begin
            rand_pkt();
            build_expect(1'b1);
            send(1'b1, 2, 1'b0);
        end
        @(posedge clk_a); #1;
        ff_rand = 1'b0;
        b1.fifo_full = 1'b0;
        b0.fifo_full = 1'b0;
        wait_drain(1'b1);
        check("rand1_pkt_count", 32'(b1.pkt_count), 32'(sent1));
        check("rand1_pulses", 32'(pulses1), 32'(sent1));

        // No-trailer instance: 2-byte packet
        pkt = '{8'h10, 8'h20};
        build_expect(1'b0);
        send(1'b0, 0, 1'b0);
        wait_drain(1'b0);
        check("t0_pulses", 32'(pulses0), 32'd1);
        check("t0_pkt_count", 32'(b0.pkt_count), 32'd1);

        // No-trailer instance: random packets (odd lengths use PAD0)
        ff_rand = 1'b1;
        for (int k = 0; k < 15; k++) begin
            rand_pkt();
            build_expect(1'b0);
            send(1'b0, 2, 1'b0);
        end
        @(posedge clk_a); #1;
        ff_rand = 1'b0;
        b1.fifo_full = 1'b0;
        b0.fifo_full = 1'b0;
        wait_drain(1'b0);
        check("rand0_pkt_count", 32'(b0.pkt_count), 32'(sent0));
        check("rand0_pulses", 32'(pulses0), 32'(sent0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
